fwd_scoreboard: RTL and testbench
=================================

Name: fwd_scoreboard

Overview:
- Parametrised successor to the two-source EX/MEM/WB forwarding unit.
- Tracks every in-flight producer across DEPTH post-ID stages, each with a per-instruction result latency.
- Drives per-source bypass selects for the instruction in EX.
- Drives a load-use style stall for the instruction in ID, and keeps a saturating stall counter and a sticky consistency-error flag.
- Sits between ID and EX, beside the hazard/pipeline-register logic.

Parameters:
- REG_ADDR_WIDTH, 5, register address width.
- NUM_SRC, 2, source operands per instruction.
- DEPTH, 3, tracked stages: 0=EX, 1=MEM, 2=WB, ...; must be at least 2.
- LAT_W, 2, width of the latency field.
- CNT_W, 16, stall counter width.
- Derived: SEL_W = $clog2(DEPTH).

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous reset, active-high
- id_valid_i  in  1  valid instruction in ID
- id_rs_i  in  NUM_SRC*REG_ADDR_WIDTH  ID source addresses; source s at slice s
- id_rs_used_i  in  NUM_SRC  source s actually read
- id_rd_i  in  REG_ADDR_WIDTH  ID destination
- id_reg_write_i  in  1  ID instruction writes rd
- id_lat_i  in  LAT_W  stage index from which the result is forwardable (1=ALU, 2=load)
- flush_i  in  1  kill ID instruction and EX entry
- stall_o  out  1  hold ID, insert bubble into EX
- fwd_sel_o  out  NUM_SRC*SEL_W  per EX source: 0 = register file, k = forward from stage k
- ex_valid_o  out  1  stage 0 holds a real instruction
- stall_cnt_o  out  CNT_W  cycles stalled, saturating
- fwd_err_o  out  1  sticky: EX consumed a not-yet-ready result

Behaviour:
- Entry fields per stage k: valid, rd, wr, lat. Stage 0 additionally holds ex_rs[s] and ex_used[s].
- Reset (asynchronous, immediate):
  - All entries invalid; ex_rs and ex_used cleared.
  - stall_cnt_o = 0, fwd_err_o = 0.
  - Hence stall_o = 0, fwd_sel_o = 0, ex_valid_o = 0.
- Latency clamp: id_lat_i = 0 is treated as 1; values above DEPTH-1 are treated as DEPTH-1.
- Matching entry: valid && wr && rd != 0 && rd == address. Among matches the youngest wins (lowest k). Older matches are ignored.
- Stall (combinational from state and ID inputs):
  - For each s with id_valid_i && id_rs_used_i[s], find the youngest match over k = 0..DEPTH-1.
  - stall_o = 1 if any such match has k+1 < lat.
  - stall_o is forced to 0 when flush_i = 1.
- Issue: issue = id_valid_i && !stall_o && !flush_i.
- Each clock edge:
  - entry[k+1] <= entry[k] for k = 0..DEPTH-2; entry[DEPTH-1] retires.
  - entry[0] <= ID fields if issue, else a bubble (valid = 0).
  - Stalls never freeze stages 1..DEPTH-1.
  - flush_i: entry[0] becomes a bubble regardless. The current entry[0] still shifts to stage 1, since it is already committed to EX.
- Forward (combinational):
  - For each s with ex_valid_o && ex_used[s], take the youngest match of ex_rs[s] over k = 1..DEPTH-1.
  - fwd_sel_o[s] = k of that match, else 0.
- Error: fwd_err_o sets and stays set until reset when a selected match has k < lat. The stall rule guarantees this never happens in a correct pipeline.
- Stall counter: stall_cnt_o increments on each cycle with stall_o = 1 and holds at all-ones.
- Same-cycle retirement: a producer leaving stage DEPTH-1 is not visible to the consumer. The register file provides write-before-read.

Decomposition:
- Shared package pipe_pkg:
  - REG_ADDR_WIDTH default.
  - FWD_RF = 0 encoding.
  - Latency constants LAT_ALU = 1, LAT_LOAD = 2.
  - fwd_entry_t struct {valid, wr, rd, lat}.
- Sub-module fwd_youngest_match: priority encoder returning hit and index for one address against all entries. Instantiated per source, once for the ID stall search and once for the EX forward search.

Test Plan (DEPTH=3):
- Assert rst_i mid-run with a load in stage 0 -> outputs drop in the same cycle: stall_o = 0, fwd_sel_o = 0, stall_cnt_o = 0, fwd_err_o = 0.
- Issue ALU rd=5 lat=1, next cycle consumer rs1=5 -> no stall; on the following cycle fwd_sel_o[0] = 1.
- Issue load rd=7 lat=2, then consumer rs2=7 -> stall_o = 1 for exactly one cycle, stall_cnt_o = 1; then fwd_sel_o[1] = 2, fwd_err_o = 0.
- Issue rd=3 twice back-to-back, then consumer rs1=3 -> fwd_sel_o[0] = 1 (youngest), not 2.
- Load writing rd=0, or a load rd=9 with the consumer's rs2=9 but id_rs_used_i[1] = 0 -> no stall, fwd_sel_o = 0.
- Load rd=4 in EX, consumer rs1=4 in ID with flush_i = 1 -> stall_o = 0, no issue, ex_valid_o = 0 next cycle; the load still reaches stage 1.

Source files
------------

// File: rtl/pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pipe_pkg
// Description : Shared pipeline constants, forwarding entry type and the
//               latency clamp used by the forwarding scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
package pipe_pkg;

    localparam int DEF_REG_ADDR_WIDTH = 5;
    localparam int DEF_LAT_W          = 2;

    // Forward-select encoding for "read the register file".
    localparam int FWD_RF   = 0;

    localparam int LAT_ALU  = 1;
    localparam int LAT_LOAD = 2;

    typedef struct packed {
        logic                          valid;
        logic                          wr;
        logic [DEF_REG_ADDR_WIDTH-1:0] rd;
        logic [DEF_LAT_W-1:0]          lat;
    } fwd_entry_t;

    // Latency 0 behaves as 1; anything beyond the last tracked stage saturates.
    function automatic int clamp_lat(input int lat, input int depth);
        if (lat < 1) begin
            return 1;
        end
        if (lat > depth - 1) begin
            return depth - 1;
        end
        return lat;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fwd_youngest_match.sv
`default_nettype none
// ============================================================================
// Module      : fwd_youngest_match
// Description : Priority search of one register address against all tracked
//               stages; reports whether any writer matches and the youngest one.
// Revision    : 1.0 - initial release
// ============================================================================
module fwd_youngest_match #(
    parameter int REG_ADDR_WIDTH = 5,
    parameter int DEPTH          = 3,
    parameter int SEL_W          = 2
) (
    input  logic [REG_ADDR_WIDTH-1:0] i_addr,
    input  logic [DEPTH-1:0]          i_valid,
    input  logic [DEPTH-1:0]          i_wr,
    input  logic [REG_ADDR_WIDTH-1:0] i_rd [DEPTH],
    output logic                      o_hit,
    output logic [SEL_W-1:0]          o_idx
);

    // Walk oldest to youngest so the lowest matching stage overwrites last.
    always_comb begin
        o_hit = 1'b0;
        o_idx = '0;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            if (i_valid[k] && i_wr[k] && (i_rd[k] != '0) && (i_rd[k] == i_addr)) begin
                o_hit = 1'b1;
                o_idx = SEL_W'(k);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/fwd_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : fwd_scoreboard
// Description : Tracks in-flight producers over DEPTH post-ID stages, drives
//               EX bypass selects, the ID stall, a stall counter and error flag.
// Revision    : 1.0 - initial release
// ============================================================================
module fwd_scoreboard
    import pipe_pkg::*;
#(
    parameter int REG_ADDR_WIDTH = DEF_REG_ADDR_WIDTH,
    parameter int NUM_SRC        = 2,
    parameter int DEPTH          = 3,
    parameter int LAT_W          = DEF_LAT_W,
    parameter int CNT_W          = 16,
    localparam int SEL_W         = $clog2(DEPTH)
) (
    input  logic                              clk_i,
    input  logic                              rst_i,
    input  logic                              id_valid_i,
    input  logic [NUM_SRC*REG_ADDR_WIDTH-1:0] id_rs_i,
    input  logic [NUM_SRC-1:0]                id_rs_used_i,
    input  logic [REG_ADDR_WIDTH-1:0]         id_rd_i,
    input  logic                              id_reg_write_i,
    input  logic [LAT_W-1:0]                  id_lat_i,
    input  logic                              flush_i,
    output logic                              stall_o,
    output logic [NUM_SRC*SEL_W-1:0]          fwd_sel_o,
    output logic                              ex_valid_o,
    output logic [CNT_W-1:0]                  stall_cnt_o,
    output logic                              fwd_err_o
);

    logic [DEPTH-1:0]                  r_valid;
    logic [DEPTH-1:0]                  r_wr;
    logic [REG_ADDR_WIDTH-1:0]         r_rd  [DEPTH];
    logic [LAT_W-1:0]                  r_lat [DEPTH];
    logic [NUM_SRC*REG_ADDR_WIDTH-1:0] r_ex_rs;
    logic [NUM_SRC-1:0]                r_ex_used;
    logic [CNT_W-1:0]                  r_stall_cnt;
    logic                              r_fwd_err;

    logic [NUM_SRC-1:0] w_id_hit;
    logic [NUM_SRC-1:0] w_ex_hit;
    logic [NUM_SRC-1:0] w_ex_take;
    logic [NUM_SRC-1:0] w_src_stall;
    logic [NUM_SRC-1:0] w_src_err;
    logic [SEL_W-1:0]   w_id_idx [NUM_SRC];
    logic [SEL_W-1:0]   w_ex_idx [NUM_SRC];
    logic [DEPTH-1:0]   w_ex_search_valid;
    logic [LAT_W-1:0]   w_id_lat;
    logic               w_stall;
    logic               w_issue;

    // The EX consumer sits in stage 0 itself, so it only forwards from older stages.
    assign w_ex_search_valid = {r_valid[DEPTH-1:1], 1'b0};

    generate
        for (genvar s = 0; s < NUM_SRC; s++) begin : g_src
            fwd_youngest_match #(
                .REG_ADDR_WIDTH (REG_ADDR_WIDTH),
                .DEPTH          (DEPTH),
                .SEL_W          (SEL_W)
            ) u_id_match (
                .i_addr  (id_rs_i[s*REG_ADDR_WIDTH +: REG_ADDR_WIDTH]),
                .i_valid (r_valid),
                .i_wr    (r_wr),
                .i_rd    (r_rd),
                .o_hit   (w_id_hit[s]),
                .o_idx   (w_id_idx[s])
            );

            fwd_youngest_match #(
                .REG_ADDR_WIDTH (REG_ADDR_WIDTH),
                .DEPTH          (DEPTH),
                .SEL_W          (SEL_W)
            ) u_ex_match (
                .i_addr  (r_ex_rs[s*REG_ADDR_WIDTH +: REG_ADDR_WIDTH]),
                .i_valid (w_ex_search_valid),
                .i_wr    (r_wr),
                .i_rd    (r_rd),
                .o_hit   (w_ex_hit[s]),
                .o_idx   (w_ex_idx[s])
            );

            // A producer at stage k is forwardable to ID one stage later, hence k+1.
            assign w_src_stall[s] = id_valid_i && id_rs_used_i[s] && w_id_hit[s] &&
                                    ((int'(w_id_idx[s]) + 1) < int'(r_lat[w_id_idx[s]]));

            assign w_ex_take[s] = r_valid[0] && r_ex_used[s] && w_ex_hit[s];
            assign w_src_err[s] = w_ex_take[s] &&
                                  (int'(w_ex_idx[s]) < int'(r_lat[w_ex_idx[s]]));

            assign fwd_sel_o[s*SEL_W +: SEL_W] = w_ex_take[s] ? w_ex_idx[s] : SEL_W'(FWD_RF);
        end
    endgenerate

    assign w_stall  = (|w_src_stall) && !flush_i;
    assign w_issue  = id_valid_i && !w_stall && !flush_i;
    assign w_id_lat = LAT_W'(clamp_lat(int'(id_lat_i), DEPTH));

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_valid     <= '0;
            r_wr        <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                r_rd[k]  <= '0;
                r_lat[k] <= '0;
            end
            r_ex_rs     <= '0;
            r_ex_used   <= '0;
            r_stall_cnt <= '0;
            r_fwd_err   <= 1'b0;
        end else begin
            // Older stages always advance; a stall only turns stage 0 into a bubble.
            for (int k = DEPTH - 1; k > 0; k--) begin
                r_valid[k] <= r_valid[k-1];
                r_wr[k]    <= r_wr[k-1];
                r_rd[k]    <= r_rd[k-1];
                r_lat[k]   <= r_lat[k-1];
            end
            r_valid[0] <= w_issue;
            r_wr[0]    <= w_issue && id_reg_write_i;
            r_rd[0]    <= id_rd_i;
            r_lat[0]   <= w_id_lat;
            r_ex_rs    <= w_issue ? id_rs_i : '0;
            r_ex_used  <= w_issue ? id_rs_used_i : '0;

            if (w_stall && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + 1'b1;
            end
            if (|w_src_err) begin
                r_fwd_err <= 1'b1;
            end
        end
    end

    assign stall_o     = w_stall;
    assign ex_valid_o  = r_valid[0];
    assign stall_cnt_o = r_stall_cnt;
    assign fwd_err_o   = r_fwd_err;

endmodule
`default_nettype wire

// File: tb/tb_fwd_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : tb_fwd_scoreboard
// Description : Directed-vector scoreboard bench for fwd_scoreboard (DEPTH=3).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fwd_scoreboard;
    import pipe_pkg::*;

    localparam int RAW   = 5;
    localparam int NSRC  = 2;
    localparam int DEPTH = 3;
    localparam int LW    = 2;
    localparam int CW    = 16;
    localparam int SW    = 2;

    logic               clk = 1'b0;
    logic               rst;
    logic               id_valid;
    logic [NSRC*RAW-1:0] id_rs;
    logic [NSRC-1:0]    id_rs_used;
    logic [RAW-1:0]     id_rd;
    logic               id_reg_write;
    logic [LW-1:0]      id_lat;
    logic               flush;
    logic               stall;
    logic [NSRC*SW-1:0] fwd_sel;
    logic               ex_valid;
    logic [CW-1:0]      stall_cnt;
    logic               fwd_err;

    always #5 clk = ~clk;

    fwd_scoreboard #(
        .REG_ADDR_WIDTH (RAW),
        .NUM_SRC        (NSRC),
        .DEPTH          (DEPTH),
        .LAT_W          (LW),
        .CNT_W          (CW)
    ) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .id_valid_i     (id_valid),
        .id_rs_i        (id_rs),
        .id_rs_used_i   (id_rs_used),
        .id_rd_i        (id_rd),
        .id_reg_write_i (id_reg_write),
        .id_lat_i       (id_lat),
        .flush_i        (flush),
        .stall_o        (stall),
        .fwd_sel_o      (fwd_sel),
        .ex_valid_o     (ex_valid),
        .stall_cnt_o    (stall_cnt),
        .fwd_err_o      (fwd_err)
    );

    typedef struct {
        int          id;
        logic        stall;
        logic [1:0]  sel0;
        logic [1:0]  sel1;
        logic        exv;
        logic [15:0] cnt;
        logic        err;
    } exp_t;

    exp_t q[$];
    int   checks  = 0;
    int   errors  = 0;
    int   step_id = 0;

    task automatic chk(input string nm, input int id, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s step %0d got %0h want %0h", nm, id, got, want);
        end
    endtask

    // Monitor: outputs are valid every cycle, so one expected record per negedge.
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("stall",     e.id, 32'(stall),          32'(e.stall));
                chk("fwd_sel0",  e.id, 32'(fwd_sel[1:0]),   32'(e.sel0));
                chk("fwd_sel1",  e.id, 32'(fwd_sel[3:2]),   32'(e.sel1));
                chk("ex_valid",  e.id, 32'(ex_valid),       32'(e.exv));
                chk("stall_cnt", e.id, 32'(stall_cnt),      32'(e.cnt));
                chk("fwd_err",   e.id, 32'(fwd_err),        32'(e.err));
            end
        end
    end

    task automatic step(
        input logic       r,   input logic       v,
        input logic [4:0] rs1, input logic [4:0] rs2, input logic [1:0] used,
        input logic [4:0] rd,  input logic       w,   input logic [1:0] lat,
        input logic       fl,
        input logic       e_st, input logic [1:0] e_s0, input logic [1:0] e_s1,
        input logic       e_ex, input logic [15:0] e_cnt, input logic e_err);
        exp_t e;
        @(posedge clk);
        #1;
        rst          = r;
        id_valid     = v;
        id_rs        = {rs2, rs1};
        id_rs_used   = used;
        id_rd        = rd;
        id_reg_write = w;
        id_lat       = lat;
        flush        = fl;
        e.id    = step_id;
        e.stall = e_st;
        e.sel0  = e_s0;
        e.sel1  = e_s1;
        e.exv   = e_ex;
        e.cnt   = e_cnt;
        e.err   = e_err;
        q.push_back(e);
        step_id++;
    endtask

    task automatic idle(input logic [1:0] e_s0, input logic [1:0] e_s1,
                        input logic e_ex, input logic [15:0] e_cnt);
        step(0, 0, 0, 0, 2'b00, 0, 0, 2'(LAT_ALU), 0, 0, e_s0, e_s1, e_ex, e_cnt, 0);
    endtask

    localparam logic [1:0] LA = 2'(LAT_ALU);
    localparam logic [1:0] LL = 2'(LAT_LOAD);

    initial begin : driver
        rst = 1'b1; id_valid = 0; id_rs = '0; id_rs_used = '0;
        id_rd = '0; id_reg_write = 0; id_lat = '0; flush = 0;

        // Reset state
        step(1, 0, 0, 0, 2'b00, 0, 0, 0,  0,  0, 0, 0, 0, 0, 0);
        // ALU rd=5, then consumer rs1=5: no stall, forward from stage 1
        step(0, 1, 0, 0, 2'b00, 5, 1, LA, 0,  0, 0, 0, 0, 0, 0);
        step(0, 1, 5, 0, 2'b01, 0, 0, LA, 0,  0, 0, 0, 1, 0, 0);
        idle(1, 0, 1, 0);
        idle(0, 0, 0, 0);
        idle(0, 0, 0, 0);
        // Load rd=7, consumer rs2=7: one stall cycle, then forward from stage 2
        step(0, 1, 0, 0, 2'b00, 7, 1, LL, 0,  0, 0, 0, 0, 0, 0);
        step(0, 1, 0, 7, 2'b10, 0, 0, LA, 0,  1, 0, 0, 1, 0, 0);
        step(0, 1, 0, 7, 2'b10, 0, 0, LA, 0,  0, 0, 0, 0, 1, 0);
        idle(0, 2, 1, 1);
        idle(0, 0, 0, 1);
        // rd=3 twice, consumer rs1=3: youngest (stage 1) wins
        step(0, 1, 0, 0, 2'b00, 3, 1, LA, 0,  0, 0, 0, 0, 1, 0);
        step(0, 1, 0, 0, 2'b00, 3, 1, LA, 0,  0, 0, 0, 1, 1, 0);
        step(0, 1, 3, 0, 2'b01, 0, 0, LA, 0,  0, 0, 0, 1, 1, 0);
        idle(1, 0, 1, 1);
        idle(0, 0, 0, 1);
        idle(0, 0, 0, 1);
        // Load writing rd=0 never matches
        step(0, 1, 0, 0, 2'b00, 0, 1, LL, 0,  0, 0, 0, 0, 1, 0);
        step(0, 1, 0, 0, 2'b01, 0, 0, LA, 0,  0, 0, 0, 1, 1, 0);
        idle(0, 0, 1, 1);
        idle(0, 0, 0, 1);
        // Load rd=9, consumer rs2=9 but source 1 unused
        step(0, 1, 0, 0, 2'b00, 9, 1, LL, 0,  0, 0, 0, 0, 1, 0);
        step(0, 1, 0, 9, 2'b01, 0, 0, LA, 0,  0, 0, 0, 1, 1, 0);
        idle(0, 0, 1, 1);
        idle(0, 0, 0, 1);
        // Load rd=4 in EX, dependent consumer flushed: no stall, no issue
        step(0, 1, 0, 0, 2'b00, 4, 1, LL, 0,  0, 0, 0, 0, 1, 0);
        step(0, 1, 4, 0, 2'b01, 0, 0, LA, 1,  0, 0, 0, 1, 1, 0);
        // Load now in stage 1; a fresh consumer issues and later sees it at stage 2
        step(0, 1, 4, 0, 2'b01, 0, 0, LA, 0,  0, 0, 0, 0, 1, 0);
        idle(2, 0, 1, 1);
        idle(0, 0, 0, 1);
        // Build stall_cnt=2 then reset mid-cycle with a load in stage 0
        step(0, 1, 0, 0, 2'b00, 7, 1, LL, 0,  0, 0, 0, 0, 1, 0);
        step(0, 1, 7, 0, 2'b01, 0, 0, LA, 0,  1, 0, 0, 1, 1, 0);
        step(0, 1, 0, 0, 2'b00, 8, 1, LL, 0,  0, 0, 0, 0, 2, 0);
        step(1, 1, 8, 0, 2'b01, 0, 0, LA, 0,  0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 2'b00, 0, 0, 0,  0,  0, 0, 0, 0, 0, 0);

        @(negedge clk);
        #1;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain pending %0d want 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
